// File: rtl/vga_timing_param_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_param_if
// Description : Run control and raster outputs of the VGA timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_param_if #(
    parameter int X_W = 12,
    parameter int Y_W = 11
);
    logic           in_run;
    logic           out_vga_hs;
    logic           out_vga_vs;
    logic           out_active;
    logic           out_vblank;
    logic [X_W-1:0] out_vga_x;
    logic [Y_W-1:0] out_vga_y;
    logic           out_pix_tick;
    logic           out_line_start;
    logic           out_frame_start;
    logic [7:0]     out_frame_count;

    // The generator drives the raster; the shading logic consumes it.
    modport master (
        input  in_run,
        output out_vga_hs, out_vga_vs, out_active, out_vblank,
        output out_vga_x, out_vga_y, out_pix_tick, out_line_start,
        output out_frame_start, out_frame_count
    );

    modport slave (
        output in_run,
        input  out_vga_hs, out_vga_vs, out_active, out_vblank,
        input  out_vga_x, out_vga_y, out_pix_tick, out_line_start,
        input  out_frame_start, out_frame_count
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_param.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_param
// Description : Parametrised VGA/DVI raster timing generator with pixel-clock
//               divider and run/pause. Optional frame counter enabled by
//               defining VGA_TIMING_FRAME_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_DIV  = 1,
    parameter int X_W      = 12,
    parameter int Y_W      = 11
) (
    input  wire logic        clock,
    input  wire logic        reset,
    vga_timing_param_if.master vif
);
    localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int C_H_CW    = $clog2(C_H_TOTAL);
    localparam int C_V_CW    = $clog2(C_V_TOTAL);
    localparam int C_D_W     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [C_D_W-1:0]  C_D_LAST   = C_D_W'(PIX_DIV - 1);
    localparam logic [C_H_CW-1:0] C_H_LAST   = C_H_CW'(C_H_TOTAL - 1);
    localparam logic [C_H_CW-1:0] C_H_ACT    = C_H_CW'(H_ACTIVE);
    localparam logic [C_H_CW-1:0] C_HS_BEG   = C_H_CW'(H_ACTIVE + H_FP);
    localparam logic [C_H_CW-1:0] C_HS_LAST  = C_H_CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [C_V_CW-1:0] C_V_LAST   = C_V_CW'(C_V_TOTAL - 1);
    localparam logic [C_V_CW-1:0] C_V_ACT    = C_V_CW'(V_ACTIVE);
    localparam logic [C_V_CW-1:0] C_VS_BEG   = C_V_CW'(V_ACTIVE + V_FP);
    localparam logic [C_V_CW-1:0] C_VS_LAST  = C_V_CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [C_D_W-1:0]  div_d, div_q;
    logic [C_H_CW-1:0] h_d, h_q;
    logic [C_V_CW-1:0] v_d, v_q;
    logic              hs_d, hs_q;
    logic              vs_d, vs_q;
    logic              active_d, active_q;
    logic              vblank_d, vblank_q;
    logic [X_W-1:0]    x_d, x_q;
    logic [Y_W-1:0]    y_d, y_q;
    logic              pix_tick_d, pix_tick_q;
    logic              line_start_d, line_start_q;
    logic              frame_start_d, frame_start_q;
    logic              pix_en;

    assign pix_en = vif.in_run && (div_q == C_D_LAST);

    always_comb begin
        div_d         = div_q;
        h_d           = h_q;
        v_d           = v_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        active_d      = active_q;
        vblank_d      = vblank_q;
        x_d           = x_q;
        y_d           = y_q;
        pix_tick_d    = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (vif.in_run) begin
            div_d = pix_en ? '0 : div_q + 1'b1;
        end

        // Outputs are a decode of the counter values being loaded this edge,
        // so (h,v) and the visible signals stay aligned with no extra stage.
        if (pix_en) begin
            if (h_q == C_H_LAST) begin
                h_d = '0;
                v_d = (v_q == C_V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end

            active_d      = (h_d < C_H_ACT) && (v_d < C_V_ACT);
            vblank_d      = (v_d >= C_V_ACT);
            x_d           = (h_d < C_H_ACT) ? X_W'(h_d) : '0;
            y_d           = (v_d < C_V_ACT) ? Y_W'(v_d) : '0;
            hs_d          = ((h_d >= C_HS_BEG) && (h_d <= C_HS_LAST)) ? HS_POL : ~HS_POL;
            vs_d          = ((v_d >= C_VS_BEG) && (v_d <= C_VS_LAST)) ? VS_POL : ~VS_POL;
            pix_tick_d    = 1'b1;
            line_start_d  = (h_d == '0);
            frame_start_d = (h_d == '0) && (v_d == '0);
        end
    end

    // Counters reset to the last position so the first tick lands on (0,0).
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q         <= '0;
            h_q           <= C_H_LAST;
            v_q           <= C_V_LAST;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            active_q      <= 1'b0;
            vblank_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            pix_tick_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            active_q      <= active_d;
            vblank_q      <= vblank_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_tick_q    <= pix_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.out_vga_hs      = hs_q;
    assign vif.out_vga_vs      = vs_q;
    assign vif.out_active      = active_q;
    assign vif.out_vblank      = vblank_q;
    assign vif.out_vga_x       = x_q;
    assign vif.out_vga_y       = y_q;
    assign vif.out_pix_tick    = pix_tick_q;
    assign vif.out_line_start  = line_start_q;
    assign vif.out_frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [7:0] frame_count_d, frame_count_q;

    always_comb begin
        frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count_q <= 8'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign vif.out_frame_count = frame_count_q;
`else
    assign vif.out_frame_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_param
// Description : Bench for vga_timing_param: default mode, PIX_DIV=3 and a small
//               positive-polarity mode checked against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_param;
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        act;
        logic        vb;
        logic [11:0] x;
        logic [10:0] y;
        logic        pt;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } exp_t;

    localparam int P_HA  [3] = '{640, 640, 4};
    localparam int P_HF  [3] = '{16, 16, 1};
    localparam int P_HS  [3] = '{96, 96, 1};
    localparam int P_HB  [3] = '{48, 48, 1};
    localparam int P_VA  [3] = '{480, 480, 3};
    localparam int P_VF  [3] = '{10, 10, 1};
    localparam int P_VS  [3] = '{2, 2, 1};
    localparam int P_VB  [3] = '{33, 33, 1};
    localparam int P_DIV [3] = '{1, 3, 1};
    localparam bit P_HP  [3] = '{1'b0, 1'b0, 1'b1};
    localparam bit P_VP  [3] = '{1'b0, 1'b0, 1'b1};

    logic clk;
    logic rst;
    logic sb_en;
    int   n_checks;
    int   n_fail;

    vga_timing_param_if #(.X_W(12), .Y_W(11)) if_a ();
    vga_timing_param_if #(.X_W(12), .Y_W(11)) if_b ();
    vga_timing_param_if #(.X_W(12), .Y_W(11)) if_c ();

    vga_timing_param u_dut_a (.clock(clk), .reset(rst), .vif(if_a));

    vga_timing_param #(.PIX_DIV(3)) u_dut_b (.clock(clk), .reset(rst), .vif(if_b));

    vga_timing_param #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut_c (.clock(clk), .reset(rst), .vif(if_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t got [3];
    assign got[0] = {if_a.out_vga_hs, if_a.out_vga_vs, if_a.out_active, if_a.out_vblank,
                     if_a.out_vga_x, if_a.out_vga_y, if_a.out_pix_tick, if_a.out_line_start,
                     if_a.out_frame_start, if_a.out_frame_count};
    assign got[1] = {if_b.out_vga_hs, if_b.out_vga_vs, if_b.out_active, if_b.out_vblank,
                     if_b.out_vga_x, if_b.out_vga_y, if_b.out_pix_tick, if_b.out_line_start,
                     if_b.out_frame_start, if_b.out_frame_count};
    assign got[2] = {if_c.out_vga_hs, if_c.out_vga_vs, if_c.out_active, if_c.out_vblank,
                     if_c.out_vga_x, if_c.out_vga_y, if_c.out_pix_tick, if_c.out_line_start,
                     if_c.out_frame_start, if_c.out_frame_count};

    function automatic logic [7:0] fc_exp(input int n);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        return 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    // Reference model: advances on each edge from the inputs seen there and
    // queues the outputs the DUT must show after that edge.
    int   md [3];
    int   mh [3];
    int   mv [3];
    int   mfc [3];
    exp_t mexp [3];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];
    exp_t e_m;
    logic run_i;
    int   ht;
    int   vt;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       run_i = if_a.in_run;
                1:       run_i = if_b.in_run;
                default: run_i = if_c.in_run;
            endcase
            ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
            vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
            e_m = mexp[i];
            e_m.pt = 1'b0;
            e_m.ls = 1'b0;
            e_m.fs = 1'b0;
            if (rst) begin
                md[i]  = 0;
                mh[i]  = ht - 1;
                mv[i]  = vt - 1;
                mfc[i] = 0;
                e_m    = '0;
                e_m.hs = !P_HP[i];
                e_m.vs = !P_VP[i];
            end else if (run_i) begin
                if (md[i] == P_DIV[i] - 1) begin
                    md[i] = 0;
                    if (mh[i] == ht - 1) begin
                        mh[i] = 0;
                        mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
                    end else begin
                        mh[i] = mh[i] + 1;
                    end
                    e_m.act = (mh[i] < P_HA[i]) && (mv[i] < P_VA[i]);
                    e_m.vb  = (mv[i] >= P_VA[i]);
                    e_m.x   = (mh[i] < P_HA[i]) ? 12'(mh[i]) : 12'd0;
                    e_m.y   = (mv[i] < P_VA[i]) ? 11'(mv[i]) : 11'd0;
                    e_m.hs  = (mh[i] >= P_HA[i] + P_HF[i] && mh[i] < P_HA[i] + P_HF[i] + P_HS[i])
                              ? P_HP[i] : !P_HP[i];
                    e_m.vs  = (mv[i] >= P_VA[i] + P_VF[i] && mv[i] < P_VA[i] + P_VF[i] + P_VS[i])
                              ? P_VP[i] : !P_VP[i];
                    e_m.pt  = 1'b1;
                    e_m.ls  = (mh[i] == 0);
                    e_m.fs  = (mh[i] == 0) && (mv[i] == 0);
                    if (e_m.fs) mfc[i] = mfc[i] + 1;
                end else begin
                    md[i] = md[i] + 1;
                end
            end
            e_m.fc  = fc_exp(mfc[i]);
            mexp[i] = e_m;
            case (i)
                0:       q0.push_back(e_m);
                1:       q1.push_back(e_m);
                default: q2.push_back(e_m);
            endcase
        end
    end

    exp_t e_c;
    logic have_e;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            have_e = 1'b0;
            e_c    = '0;
            case (i)
                0:       if (q0.size() > 0) begin e_c = q0.pop_front(); have_e = 1'b1; end
                1:       if (q1.size() > 0) begin e_c = q1.pop_front(); have_e = 1'b1; end
                default: if (q2.size() > 0) begin e_c = q2.pop_front(); have_e = 1'b1; end
            endcase
            if (sb_en) begin
                n_checks++;
                if (!have_e) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty inst%0d t=%0t got=%h required=entry", i, $time, got[i]);
                end else if (got[i] !== e_c) begin
                    n_fail++;
                    $display("FAIL scoreboard inst%0d t=%0t got=%h required=%h", i, $time, got[i], e_c);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb_en = 1'b1;
        n_checks++;
        if ({if_a.out_vga_hs, if_a.out_vga_vs, if_a.out_active, if_a.out_vblank} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_a_levels: got %b required 1100",
                     {if_a.out_vga_hs, if_a.out_vga_vs, if_a.out_active, if_a.out_vblank});
        end
        n_checks++;
        if (if_a.out_vga_x !== 12'd0 || if_a.out_vga_y !== 11'd0 || if_a.out_frame_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_a_xy: got x=%0d y=%0d fc=%0d required 0 0 0",
                     if_a.out_vga_x, if_a.out_vga_y, if_a.out_frame_count);
        end
        n_checks++;
        if ({if_c.out_vga_hs, if_c.out_vga_vs, if_c.out_pix_tick} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_c_levels: got %b required 000",
                     {if_c.out_vga_hs, if_c.out_vga_vs, if_c.out_pix_tick});
        end
        rst = 1'b0;
    endtask

    task automatic test_first_tick();
        @(posedge clk);
        #1;
        n_checks++;
        if ({if_a.out_frame_start, if_a.out_line_start, if_a.out_active, if_a.out_pix_tick} !== 4'b1111) begin
            n_fail++;
            $display("FAIL first_tick_a: got fs/ls/act/pt=%b required 1111",
                     {if_a.out_frame_start, if_a.out_line_start, if_a.out_active, if_a.out_pix_tick});
        end
        n_checks++;
        if (if_a.out_vga_x !== 12'd0 || if_a.out_vga_y !== 11'd0) begin
            n_fail++;
            $display("FAIL first_tick_xy: got x=%0d y=%0d required 0 0", if_a.out_vga_x, if_a.out_vga_y);
        end
        n_checks++;
        if (if_c.out_frame_start !== 1'b1 || if_b.out_pix_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL first_tick_bc: got c_fs=%b b_pt=%b required 1 0",
                     if_c.out_frame_start, if_b.out_pix_tick);
        end
    endtask

    task automatic test_pix_div();
        int t;
        int k;
        @(posedge clk);
        #1;
        n_checks++;
        if (if_b.out_pix_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL div_edge2: got pt=%b required 0", if_b.out_pix_tick);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({if_b.out_pix_tick, if_b.out_frame_start} !== 2'b11 || if_b.out_vga_x !== 12'd0) begin
            n_fail++;
            $display("FAIL div_edge3: got pt/fs=%b x=%0d required 11 x=0",
                     {if_b.out_pix_tick, if_b.out_frame_start}, if_b.out_vga_x);
        end
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (if_b.out_pix_tick !== (j % 3 == 0) || if_b.out_vga_x !== 12'(j / 3)) begin
                n_fail++;
                $display("FAIL div_step%0d: got pt=%b x=%0d required pt=%b x=%0d",
                         j, if_b.out_pix_tick, if_b.out_vga_x, (j % 3 == 0), j / 3);
            end
        end
        t = 0;
        while (if_b.out_line_start !== 1'b1 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (if_b.out_line_start !== 1'b1 && k < 3000);
        n_checks++;
        if (k != 2400) begin
            n_fail++;
            $display("FAIL div_line_period: got %0d clocks required 2400", k);
        end
    endtask

    task automatic test_hsync();
        int t;
        int cnt;
        int first;
        t = 0;
        while (if_a.out_line_start !== 1'b1 && t < 900) begin
            @(posedge clk);
            #1;
            t++;
        end
        cnt   = 0;
        first = -1;
        for (int k = 1; k <= 800; k++) begin
            @(posedge clk);
            #1;
            if (k < 800 && if_a.out_vga_hs === 1'b0) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (k == 800) begin
                n_checks++;
                if (if_a.out_line_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL line_period_a: got ls=%b at 800 clocks required 1", if_a.out_line_start);
                end
            end
        end
        n_checks++;
        if (cnt != 96 || first != 656) begin
            n_fail++;
            $display("FAIL hsync_window: got %0d ticks from h=%0d required 96 from h=656", cnt, first);
        end
    endtask

    task automatic test_small();
        int t;
        int hs_cnt;
        int vs_cnt;
        int vb_cnt;
        int fs_cnt;
        logic [11:0] xs [7];
        xs = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd0, 12'd0, 12'd0};
        t = 0;
        while (if_c.out_frame_start !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        hs_cnt = 0;
        vs_cnt = 0;
        vb_cnt = 0;
        fs_cnt = 0;
        for (int k = 1; k <= 42; k++) begin
            @(posedge clk);
            #1;
            if (k <= 6) begin
                n_checks++;
                if (if_c.out_vga_x !== xs[k]) begin
                    n_fail++;
                    $display("FAIL small_x%0d: got %0d required %0d", k, if_c.out_vga_x, xs[k]);
                end
            end
            if (k < 42) begin
                if (if_c.out_vga_hs === 1'b1) hs_cnt++;
                if (if_c.out_vga_vs === 1'b1) vs_cnt++;
                if (if_c.out_vblank === 1'b1) vb_cnt++;
                if (if_c.out_frame_start === 1'b1) fs_cnt++;
            end
        end
        n_checks++;
        if (hs_cnt != 6 || vs_cnt != 7 || vb_cnt != 21) begin
            n_fail++;
            $display("FAIL small_sync_counts: got hs=%0d vs=%0d vb=%0d required 6 7 21", hs_cnt, vs_cnt, vb_cnt);
        end
        n_checks++;
        if (fs_cnt != 0 || if_c.out_frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL small_frame_period: got early fs=%0d fs@42=%b required 0 1", fs_cnt, if_c.out_frame_start);
        end
    endtask

    task automatic test_freeze();
        int t;
        t = 0;
        while (if_a.out_vga_x !== 12'd100 && t < 900) begin
            @(posedge clk);
            #1;
            t++;
        end
        if_a.in_run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (if_a.out_vga_x !== 12'd100 || if_a.out_pix_tick !== 1'b0 || if_a.out_line_start !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze%0d: got x=%0d pt=%b ls=%b required 100 0 0",
                         k, if_a.out_vga_x, if_a.out_pix_tick, if_a.out_line_start);
            end
        end
        if_a.in_run = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (if_a.out_vga_x !== 12'd101 || if_a.out_pix_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL resume: got x=%0d pt=%b required 101 1", if_a.out_vga_x, if_a.out_pix_tick);
        end
    endtask

    task automatic test_reset_mid();
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({if_c.out_vga_hs, if_c.out_active, if_c.out_frame_start} !== 3'b000 ||
            if_c.out_vga_x !== 12'd0 || if_a.out_active !== 1'b0 || if_a.out_vga_hs !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got c_hs/act/fs=%b c_x=%0d a_act=%b a_hs=%b required 000 0 0 1",
                     {if_c.out_vga_hs, if_c.out_active, if_c.out_frame_start}, if_c.out_vga_x,
                     if_a.out_active, if_a.out_vga_hs);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (if_c.out_frame_start !== 1'b1 || if_c.out_active !== 1'b1 || if_a.out_frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got c_fs=%b c_act=%b a_fs=%b required 1 1 1",
                     if_c.out_frame_start, if_c.out_active, if_a.out_frame_start);
        end
    endtask

    task automatic test_frame_count();
        int fs_cnt;
        int t;
        fs_cnt = 1;
        n_checks++;
        if (if_c.out_frame_count !== fc_exp(1)) begin
            n_fail++;
            $display("FAIL fc_first: got %0d required %0d", if_c.out_frame_count, fc_exp(1));
        end
        t = 0;
        while (fs_cnt < 256 && t < 256 * 42 + 100) begin
            @(posedge clk);
            #1;
            t++;
            if (if_c.out_frame_start === 1'b1) begin
                fs_cnt++;
                n_checks++;
                if (if_c.out_frame_count !== fc_exp(fs_cnt)) begin
                    n_fail++;
                    $display("FAIL fc_frame%0d: got %0d required %0d", fs_cnt, if_c.out_frame_count, fc_exp(fs_cnt));
                end
            end
        end
        n_checks++;
        if (fs_cnt != 256 || if_c.out_frame_count !== 8'd0) begin
            n_fail++;
            $display("FAIL fc_wrap: got %0d frames fc=%0d required 256 frames fc=0", fs_cnt, if_c.out_frame_count);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        sb_en       = 1'b0;
        rst         = 1'b1;
        if_a.in_run = 1'b1;
        if_b.in_run = 1'b1;
        if_c.in_run = 1'b1;
        test_reset();
        test_first_tick();
        test_pix_div();
        test_hsync();
        test_small();
        test_freeze();
        test_reset_mid();
        test_frame_count();
        @(posedge clk);
        #1;
        sb_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
